// File: rtl/cpu_pkg.sv
// Shared definitions for tiny_cpu_core: opcodes, ALU ops, controller states
// and instruction field positions.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int INSN_W = 16;
    localparam int NUM_REGS = 4;
    localparam int MEM_DEPTH = 256;

    // Instruction field positions
    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RD_LO = 8;
    localparam int RA_LO = 4;
    localparam int RB_LO = 0;
    localparam int IMM_LO = 0;

    localparam logic [3:0] OP_LOAD = 4'b1000;
    localparam logic [3:0] OP_INC  = 4'b1010;
    localparam logic [3:0] OP_DEC  = 4'b1011;
    localparam logic [3:0] OP_HLT  = 4'b1100;
    localparam logic [3:0] OP_JMP  = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_PA  = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    // Top bit clear means a three-register ALU instruction.
    function automatic logic is_alu_op(input logic [3:0] op);
        return !op[3];
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU; all results wrap modulo 256, no flags.
module alu
    import cpu_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_PA:  y = a;
            ALU_SHL: y = {a[DATA_W-2:0], 1'b0};
            ALU_SHR: y = {1'b0, a[DATA_W-1:1]};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/tiny_cpu_core.sv
// Minimal 8-bit core: 256x16 program memory, 4x8 register file, ALU and a
// two-phase fetch/execute controller with a debug read port.
module tiny_cpu_core
    import cpu_pkg::*;
#(
    parameter string PROG_INIT = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              prog_we,
    input  logic [7:0]        prog_addr,
    input  logic [INSN_W-1:0] prog_wdata,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic [7:0]        pc,
    output logic [INSN_W-1:0] ir,
    output logic [DATA_W-1:0] alu_out,
    output logic              halted
);

    logic [INSN_W-1:0]                mem [0:MEM_DEPTH-1];
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
    state_t                           state;

    logic [3:0]        op;
    logic [1:0]        rd, ra, rb;
    logic [7:0]        imm;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a, alu_b;

    assign op  = ir[OP_HI:OP_LO];
    assign rd  = ir[RD_LO +: 2];
    assign ra  = ir[RA_LO +: 2];
    assign rb  = ir[RB_LO +: 2];
    assign imm = ir[IMM_LO +: 8];

    // Program memory port; the fetch below reads the pre-write word on a collision.
    always_ff @(posedge clk) begin
        if (prog_we)
            mem[prog_addr] <= prog_wdata;
    end

    // INC/DEC reuse the adder on R[rd] with a constant 1.
    always_comb begin
        if (is_alu_op(op)) begin
            alu_op = op[2:0];
            alu_a  = regs[ra];
            alu_b  = regs[rb];
        end else begin
            alu_op = (op == OP_DEC) ? ALU_SUB : ALU_ADD;
            alu_a  = regs[rd];
            alu_b  = 8'd1;
        end
    end

    alu u_alu (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_out)
    );

    assign dbg_data = regs[dbg_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            regs   <= '0;
            halted <= 1'b0;
        end else if (run) begin
            case (state)
                FETCH: begin
                    ir    <= mem[pc];
                    state <= EXEC;
                end
                EXEC: begin
                    state <= FETCH;
                    pc    <= pc + 8'd1;
                    if (is_alu_op(op)) begin
                        regs[rd] <= alu_out;
                    end else begin
                        case (op)
                            OP_LOAD:        regs[rd] <= imm;
                            OP_INC, OP_DEC: regs[rd] <= alu_out;
                            OP_JMP:         pc <= imm;
                            OP_HLT: begin
                                pc     <= pc;
                                state  <= HALT;
                                halted <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_tiny_cpu_core.sv
// Directed bench for tiny_cpu_core: small programs with hand-computed results.
module tb_tiny_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [15:0] prog_wdata = '0;
    logic [1:0]  dbg_sel = '0;
    logic [7:0]  dbg_data;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [7:0]  alu_out;
    logic        halted;

    int checks = 0;
    int errors = 0;

    tiny_cpu_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .pc         (pc),
        .ir         (ir),
        .alu_out    (alu_out),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input int r, input logic [7:0] exp);
        dbg_sel = 2'(r);
        #1;
        chk(tag, {8'h00, dbg_data}, {8'h00, exp});
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = d;
        @(negedge clk);
        prog_we    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_cycles(input int n);
        run = 1'b1;
        repeat (n) @(negedge clk);
        run = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_pc", {8'h00, pc}, 16'h0000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_halted", {15'h0, halted}, 16'h0000);
        for (int r = 0; r < 4; r++) chk_reg("rst_reg", r, 8'h00);

        // LOAD / ADD / HLT
        load(8'h00, 16'h8005);
        load(8'h01, 16'h8103);
        load(8'h02, 16'h0201);
        load(8'h03, 16'hC000);
        do_reset();
        run_cycles(8);
        chk_reg("p1_r0", 0, 8'h05);
        chk_reg("p1_r1", 1, 8'h03);
        chk_reg("p1_r2", 2, 8'h08);
        chk("p1_halted", {15'h0, halted}, 16'h0001);
        chk("p1_pc", {8'h00, pc}, 16'h0003);

        // SUB wrap and AND, with a peek at the ALU mid-EXEC
        load(8'h00, 16'h8003);
        load(8'h01, 16'h8105);
        load(8'h02, 16'h1301);
        load(8'h03, 16'h2201);
        load(8'h04, 16'hC000);
        do_reset();
        run_cycles(5);
        chk("p2_ir_sub", ir, 16'h1301);
        chk("p2_alu_sub", {8'h00, alu_out}, 16'h00FE);
        chk_reg("p2_r3_pending", 3, 8'h00);
        run_cycles(5);
        chk_reg("p2_r3", 3, 8'hFE);
        chk_reg("p2_r2", 2, 8'h01);
        chk("p2_pc", {8'h00, pc}, 16'h0004);

        // Remaining ALU ops
        load(8'h00, 16'h8096);
        load(8'h01, 16'h8103);
        load(8'h02, 16'h3201);
        load(8'h03, 16'h4301);
        load(8'h04, 16'h5200);
        load(8'h05, 16'h6300);
        load(8'h06, 16'h7100);
        load(8'h07, 16'hC000);
        do_reset();
        run_cycles(6);
        chk_reg("p3_or", 2, 8'h97);
        run_cycles(2);
        chk_reg("p3_xor", 3, 8'h95);
        run_cycles(8);
        chk_reg("p3_pass", 2, 8'h96);
        chk_reg("p3_shl", 3, 8'h2C);
        chk_reg("p3_shr", 1, 8'h4B);
        chk("p3_pc", {8'h00, pc}, 16'h0007);

        // INC/DEC wrap
        load(8'h00, 16'h80FF);
        load(8'h01, 16'hA000);
        load(8'h02, 16'h8100);
        load(8'h03, 16'hB100);
        load(8'h04, 16'hC000);
        do_reset();
        run_cycles(10);
        chk_reg("p4_inc", 0, 8'h00);
        chk_reg("p4_dec", 1, 8'hFF);
        chk("p4_halted", {15'h0, halted}, 16'h0001);

        // JMP
        load(8'h00, 16'hF010);
        load(8'h01, 16'h80AA);
        load(8'h10, 16'h8155);
        load(8'h11, 16'hC000);
        do_reset();
        run_cycles(6);
        chk_reg("p5_r0", 0, 8'h00);
        chk_reg("p5_r1", 1, 8'h55);
        chk("p5_pc", {8'h00, pc}, 16'h0011);
        chk("p5_halted", {15'h0, halted}, 16'h0001);

        // NOP, run stall mid-EXEC, HALT absorbing
        load(8'h00, 16'h9000);
        load(8'h01, 16'hC000);
        do_reset();
        run_cycles(1);
        repeat (3) @(negedge clk);
        chk("p6_stall_pc", {8'h00, pc}, 16'h0000);
        chk("p6_stall_ir", ir, 16'h9000);
        chk("p6_stall_halted", {15'h0, halted}, 16'h0000);
        run_cycles(3);
        chk("p6_halted", {15'h0, halted}, 16'h0001);
        chk("p6_pc", {8'h00, pc}, 16'h0001);
        run_cycles(4);
        chk("p6_absorb_pc", {8'h00, pc}, 16'h0001);
        chk("p6_absorb_halted", {15'h0, halted}, 16'h0001);
        for (int r = 0; r < 4; r++) chk_reg("p6_reg", r, 8'h00);

        // Asynchronous reset during EXEC of an ADD
        load(8'h00, 16'h8005);
        load(8'h01, 16'h8103);
        load(8'h02, 16'h0201);
        load(8'h03, 16'hC000);
        do_reset();
        run_cycles(5);
        chk("p7_pre_ir", ir, 16'h0201);
        chk_reg("p7_pre_r0", 0, 8'h05);
        #1 rst_n = 1'b0;
        #1;
        chk("p7_rst_pc", {8'h00, pc}, 16'h0000);
        chk("p7_rst_ir", ir, 16'h0000);
        chk("p7_rst_halted", {15'h0, halted}, 16'h0000);
        for (int r = 0; r < 4; r++) chk_reg("p7_rst_reg", r, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cycles(8);
        chk_reg("p7_r2", 2, 8'h08);
        chk("p7_pc", {8'h00, pc}, 16'h0003);
        chk("p7_halted", {15'h0, halted}, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
